hyper_trap_arb: RTL

Hardware trap arbiter and sequencer in front of `hyper_ctrl`. It latches trap events from several hardware sources and one software (I/O-write) trap path, picks one winner, and presents a single trap request plus a 7-bit trap port. It holds that request until hypervisor entry is acknowledged, then blocks further traps until hypervisor exit and a holdoff period have both completed.

---
 rtl/hyper_pkg.sv | 17 +
 rtl/hyper_rr_pick.sv | 38 +++
 rtl/hyper_trap_arb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hyper_pkg.sv
// hyper_pkg: definitions shared by the trap arbiter and its round-robin picker.
//   state_e              - arbiter FSM state encoding
//   TRAP_PORT_W          - width of a trap port number
//   HW_PORT_BASE_DEFAULT - trap port used by hardware source 0 unless overridden
package hyper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_IN_HYPER = 2'd2,
    ST_HOLDOFF  = 2'd3
  } state_e;

  localparam int TRAP_PORT_W = 7;
  localparam logic [TRAP_PORT_W-1:0] HW_PORT_BASE_DEFAULT = 7'h40;

endpackage

// File: rtl/hyper_rr_pick.sv
// hyper_rr_pick: combinational round-robin picker.
//   req_i   [NUM_SRC] - request vector
//   start_i [IDX_W]   - index where the search begins (must be < NUM_SRC)
//   grant_o [IDX_W]   - first requesting index at or after start_i, wrapping
//   any_o             - at least one request present
module hyper_rr_pick #(
  parameter int NUM_SRC = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               any_o
);

  logic [2*NUM_SRC-1:0] dbl;
  logic [NUM_SRC-1:0]   rot;
  logic [IDX_W:0]       sum;

  always_comb begin
    // Rotate so that bit 0 of rot corresponds to start_i.
    dbl   = {req_i, req_i} >> start_i;
    rot   = dbl[NUM_SRC-1:0];
    any_o = |rot;
    sum   = '0;
    // Descending scan: the lowest rotated offset is written last and wins.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, start_i} + (IDX_W + 1)'(k);
      end
    end
    if (sum >= (IDX_W + 1)'(NUM_SRC)) begin
      sum = sum - (IDX_W + 1)'(NUM_SRC);
    end
    grant_o = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/hyper_trap_arb.sv
// hyper_trap_arb: trap arbiter / sequencer in front of hyper_ctrl.
//   clk, reset_n        - clock, asynchronous active-low reset
//   trap_src, trap_mask - hardware trap events and per-source win masks
//   sw_trap_req/port    - software trap strobe and its port number
//   ready               - CPU bus ready, gates starting a new request
//   hyper_mode          - hypervisor-mode flag, used as acknowledge
//   trap_req, trap_port - single registered trap request and its port
//   trap_pending        - latched, not yet serviced hardware events
//   busy                - FSM not in IDLE
//   ack_timeout_err     - sticky: a request went unacknowledged too long
module hyper_trap_arb
  import hyper_pkg::*;
#(
  parameter int                     NUM_SRC      = 8,
  parameter logic [TRAP_PORT_W-1:0] HW_PORT_BASE = HW_PORT_BASE_DEFAULT,
  parameter int                     HOLDOFF      = 4,
  parameter int                     ACK_TIMEOUT  = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SRC-1:0]     trap_src,
  input  logic [NUM_SRC-1:0]     trap_mask,
  input  logic                   sw_trap_req,
  input  logic [TRAP_PORT_W-2:0] sw_trap_port,
  input  logic                   ready,
  input  logic                   hyper_mode,
  output logic                   trap_req,
  output logic [TRAP_PORT_W-1:0] trap_port,
  output logic [NUM_SRC-1:0]     trap_pending,
  output logic                   busy,
  output logic                   ack_timeout_err
);

  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_MAX = (ACK_TIMEOUT > HOLDOFF) ? ACK_TIMEOUT : HOLDOFF;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic [NUM_SRC-1:0]       pending_q, pending_d, clr_vec;
  logic [IDX_W-1:0]         rr_q, rr_d;
  logic [IDX_W-1:0]         win_idx_q, win_idx_d;
  logic                     win_sw_q, win_sw_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     req_q, req_d;
  logic [TRAP_PORT_W-1:0]   port_q, port_d;
  logic                     err_q, err_d;

  logic [NUM_SRC-1:0]       elig;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_any;

  assign elig = pending_q & ~trap_mask;

  hyper_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (elig),
    .start_i (rr_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    port_d    = port_q;
    win_sw_d  = win_sw_q;
    win_idx_d = win_idx_q;
    rr_d      = rr_q;
    err_d     = err_q;
    clr_vec   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (hyper_mode) begin
          // Hypervisor entered by some other path; stay out of the way.
          state_d = ST_IN_HYPER;
        end else if (ready && (sw_trap_req || pick_any)) begin
          req_d     = 1'b1;
          cnt_d     = '0;
          state_d   = ST_REQ;
          win_idx_d = pick_idx;
          if (sw_trap_req) begin
            win_sw_d = 1'b1;
            port_d   = {1'b0, sw_trap_port};
          end else begin
            win_sw_d = 1'b0;
            port_d   = HW_PORT_BASE + TRAP_PORT_W'(pick_idx);
          end
        end
      end
      ST_REQ: begin
        if (hyper_mode) begin
          req_d   = 1'b0;
          state_d = ST_IN_HYPER;
          if (!win_sw_q) begin
            clr_vec = NUM_SRC'(1) << win_idx_q;
            rr_d    = (win_idx_q == IDX_W'(NUM_SRC - 1)) ? '0 : win_idx_q + 1'b1;
          end
        end else if (cnt_q == ACK_LAST) begin
          // Drops exactly ACK_TIMEOUT cycles after the rise; pending kept.
          req_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLDOFF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IN_HYPER: begin
        if (!hyper_mode) begin
          if (HOLDOFF == 0) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = HOLD_LOAD;
            state_d = ST_HOLDOFF;
          end
        end
      end
      ST_HOLDOFF: begin
        if (hyper_mode) begin
          cnt_d   = '0;
          state_d = ST_IN_HYPER;
        end else if (cnt_q <= 1) begin
          // Leaving on the edge that counts 1 -> 0 gives HOLDOFF+2 exit-to-request.
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new event on the acknowledge cycle keeps the bit set.
    pending_d = (pending_q & ~clr_vec) | trap_src;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      rr_q      <= '0;
      win_idx_q <= '0;
      win_sw_q  <= 1'b0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      port_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      win_idx_q <= win_idx_d;
      win_sw_q  <= win_sw_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      port_q    <= port_d;
      err_q     <= err_d;
    end
  end

  assign trap_req        = req_q;
  assign trap_port       = port_q;
  assign trap_pending    = pending_q;
  assign busy            = (state_q != ST_IDLE);
  assign ack_timeout_err = err_q;

endmodule
